// File: rtl/core_pkg.sv
// Shared definitions for the MIPS core pipeline.
//   - ALU operation codes as seen on the EX-stage ALU 'signal' input.
//     Bit 2 set means "invert B, carry-in 1", which is how SUB and SLT
//     are built on the adder.
//   - Opcode / funct values of the supported instruction subset.
//   - ex_ctrl_t: control bundle carried from ID into EX.
package core_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SRL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic branch;
        logic valid;
    } ex_ctrl_t;

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decoder for the ID/EX stage.
// Ports:
//   opcode_i, funct_i, rs_i, rt_i, imm_i : instruction fields
//   alu_op_o   : ALU operation code
//   ctrl_o     : control bundle; valid=1 only for supported, non-NOP ops.
//                regwrite here is raw (the $0 override happens in the top)
//   use_imm_o  : operand B is the sign-extended immediate
//   is_srl_o   : shift amount must be passed through
//   rd_rs_o    : instruction really reads rs
//   rd_rt_o    : instruction really reads rt
//   dst_rt_o   : destination is rt (I-type writers) instead of rd
//   illegal_o  : unsupported encoding (the all-zero word is not illegal)
import core_pkg::*;

module id_decode #(
    parameter int RW = 5
) (
    input  logic [5:0]    opcode_i,
    input  logic [5:0]    funct_i,
    input  logic [RW-1:0] rs_i,
    input  logic [RW-1:0] rt_i,
    input  logic [15:0]   imm_i,
    output logic [2:0]    alu_op_o,
    output ex_ctrl_t      ctrl_o,
    output logic          use_imm_o,
    output logic          is_srl_o,
    output logic          rd_rs_o,
    output logic          rd_rt_o,
    output logic          dst_rt_o,
    output logic          illegal_o
);

    // imm_i covers rd/shamt/funct, so this is the whole 32-bit word == 0
    logic is_nop;
    assign is_nop = (opcode_i == OP_RTYPE) && (rs_i == '0) && (rt_i == '0) && (imm_i == '0);

    always_comb begin
        alu_op_o  = ALU_AND;
        ctrl_o    = '0;
        use_imm_o = 1'b0;
        is_srl_o  = 1'b0;
        rd_rs_o   = 1'b0;
        rd_rt_o   = 1'b0;
        dst_rt_o  = 1'b0;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.valid    = 1'b1;
                ctrl_o.regwrite = 1'b1;
                rd_rs_o         = 1'b1;
                rd_rt_o         = 1'b1;
                case (funct_i)
                    FN_ADD: alu_op_o = ALU_ADD;
                    FN_SUB: alu_op_o = ALU_SUB;
                    FN_AND: alu_op_o = ALU_AND;
                    FN_OR:  alu_op_o = ALU_OR;
                    FN_SLT: alu_op_o = ALU_SLT;
                    FN_SRL: begin
                        alu_op_o = ALU_SRL;
                        is_srl_o = 1'b1;
                        rd_rs_o  = 1'b0;   // srl only shifts rt
                    end
                    default: begin
                        ctrl_o    = '0;
                        rd_rs_o   = 1'b0;
                        rd_rt_o   = 1'b0;
                        illegal_o = ~is_nop;
                    end
                endcase
            end
            OP_ADDI: begin
                alu_op_o        = ALU_ADD;
                ctrl_o.valid    = 1'b1;
                ctrl_o.regwrite = 1'b1;
                use_imm_o       = 1'b1;
                rd_rs_o         = 1'b1;
                dst_rt_o        = 1'b1;
            end
            OP_LW: begin
                alu_op_o        = ALU_ADD;
                ctrl_o.valid    = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memread  = 1'b1;
                use_imm_o       = 1'b1;
                rd_rs_o         = 1'b1;
                dst_rt_o        = 1'b1;
            end
            OP_SW: begin
                alu_op_o        = ALU_ADD;
                ctrl_o.valid    = 1'b1;
                ctrl_o.memwrite = 1'b1;
                use_imm_o       = 1'b1;
                rd_rs_o         = 1'b1;
                rd_rt_o         = 1'b1;   // store data
            end
            OP_BEQ: begin
                alu_op_o      = ALU_SUB;
                ctrl_o.valid  = 1'b1;
                ctrl_o.branch = 1'b1;
                rd_rs_o       = 1'b1;
                rd_rt_o       = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage feeding the 32-bit EX-stage ALU.
// Decodes the ID instruction, selects/forwards operands, detects hazards
// and registers everything so the ALU sees stable operands one cycle later.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   id_*                     : instruction fields and register-file data
//   ex_alu_result            : ALU result of the instruction held here
//   mem_regwrite/rd/result   : MEM-stage writeback
//   ext_stall, flush         : hold contents / load a bubble
//   ex_signal/dataA/dataB/shamt : ALU inputs
//   ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_valid,
//   ex_store_data            : EX-stage control and sw data
//   hazard_stall             : combinational, freezes PC and IF/ID
//   illegal                  : registered, unsupported instruction captured
// Build option: define ID_EX_FWD_EN for EX/MEM forwarding with load-use
// stalls only; without it operands come straight from the register file
// and any RAW dependency on EX or MEM stalls.
import core_pkg::*;

module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [5:0]    id_opcode,
    input  logic [5:0]    id_funct,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [4:0]    id_shamt,
    input  logic [15:0]   id_imm,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] ex_alu_result,
    input  logic          mem_regwrite,
    input  logic [RW-1:0] mem_rd,
    input  logic [DW-1:0] mem_result,
    input  logic          ext_stall,
    input  logic          flush,
    output logic [2:0]    ex_signal,
    output logic [DW-1:0] ex_dataA,
    output logic [DW-1:0] ex_dataB,
    output logic [4:0]    ex_shamt,
    output logic [RW-1:0] ex_rd,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_branch,
    output logic          ex_valid,
    output logic [DW-1:0] ex_store_data,
    output logic          hazard_stall,
    output logic          illegal
);

    logic [2:0]    signal_q, signal_d;
    logic [DW-1:0] dataA_q, dataA_d, dataB_q, dataB_d, store_q, store_d;
    logic [4:0]    shamt_q, shamt_d;
    logic [RW-1:0] rd_q, rd_d;
    ex_ctrl_t      ctrl_q, ctrl_d;
    logic          illegal_q, illegal_d;

    logic [2:0] dec_alu;
    ex_ctrl_t   dec_ctrl;
    logic       dec_use_imm, dec_srl, dec_rd_rs, dec_rd_rt, dec_dst_rt, dec_illegal;

    id_decode #(.RW(RW)) u_dec (
        .opcode_i  (id_opcode),
        .funct_i   (id_funct),
        .rs_i      (id_rs),
        .rt_i      (id_rt),
        .imm_i     (id_imm),
        .alu_op_o  (dec_alu),
        .ctrl_o    (dec_ctrl),
        .use_imm_o (dec_use_imm),
        .is_srl_o  (dec_srl),
        .rd_rs_o   (dec_rd_rs),
        .rd_rt_o   (dec_rd_rt),
        .dst_rt_o  (dec_dst_rt),
        .illegal_o (dec_illegal)
    );

    logic [DW-1:0] rs_val, rt_val;
    logic          rs_live, rt_live, hazard;

`ifdef ID_EX_FWD_EN
    // A load in EX has no data yet, so it is never an EX forwarding source;
    // that case is covered by the load-use stall instead.
    logic ex_fwd_rs, ex_fwd_rt, mem_fwd_rs, mem_fwd_rt;
    assign ex_fwd_rs  = ctrl_q.valid & ctrl_q.regwrite & ~ctrl_q.memread
                      & (rd_q == id_rs) & (id_rs != '0);
    assign ex_fwd_rt  = ctrl_q.valid & ctrl_q.regwrite & ~ctrl_q.memread
                      & (rd_q == id_rt) & (id_rt != '0);
    assign mem_fwd_rs = mem_regwrite & (mem_rd == id_rs) & (id_rs != '0);
    assign mem_fwd_rt = mem_regwrite & (mem_rd == id_rt) & (id_rt != '0);
    assign rs_val  = ex_fwd_rs ? ex_alu_result : (mem_fwd_rs ? mem_result : id_rs_data);
    assign rt_val  = ex_fwd_rt ? ex_alu_result : (mem_fwd_rt ? mem_result : id_rt_data);
    assign rs_live = ctrl_q.valid & ctrl_q.memread & (rd_q != '0) & (rd_q == id_rs);
    assign rt_live = ctrl_q.valid & ctrl_q.memread & (rd_q != '0) & (rd_q == id_rt);
`else
    // No bypass network: wait until every in-flight producer has retired.
    logic unused_fwd;
    assign unused_fwd = ^{ex_alu_result, mem_result};
    assign rs_val  = id_rs_data;
    assign rt_val  = id_rt_data;
    assign rs_live = (id_rs != '0)
                   & ((ctrl_q.valid & ctrl_q.regwrite & (rd_q == id_rs))
                   |  (mem_regwrite & (mem_rd == id_rs)));
    assign rt_live = (id_rt != '0)
                   & ((ctrl_q.valid & ctrl_q.regwrite & (rd_q == id_rt))
                   |  (mem_regwrite & (mem_rd == id_rt)));
`endif

    assign hazard       = id_valid & ((dec_rd_rs & rs_live) | (dec_rd_rt & rt_live));
    assign hazard_stall = hazard & ~flush;

    // Destination: rt for addi/lw, rd for R-type, none for sw/beq.
    logic [RW-1:0] dest;
    logic          load_cap, load_bub;

    assign dest = dec_dst_rt ? id_rt : (dec_ctrl.regwrite ? id_rd : '0);

    always_comb begin
        load_cap = 1'b0;
        load_bub = 1'b0;
        if (flush) begin
            load_bub = 1'b1;
        end else if (!ext_stall) begin
            if (id_valid && !hazard && dec_ctrl.valid) load_cap = 1'b1;
            else                                       load_bub = 1'b1;
        end
    end

    always_comb begin
        signal_d  = signal_q;
        dataA_d   = dataA_q;
        dataB_d   = dataB_q;
        shamt_d   = shamt_q;
        rd_d      = rd_q;
        ctrl_d    = ctrl_q;
        store_d   = store_q;
        illegal_d = illegal_q;
        if (load_cap) begin
            signal_d        = dec_alu;
            dataA_d         = rs_val;
            dataB_d         = dec_use_imm ? {{(DW-16){id_imm[15]}}, id_imm} : rt_val;
            shamt_d         = dec_srl ? id_shamt : 5'd0;
            rd_d            = dest;
            ctrl_d          = dec_ctrl;
            ctrl_d.regwrite = dec_ctrl.regwrite & (dest != '0);
            store_d         = rt_val;
            illegal_d       = 1'b0;
        end else if (load_bub) begin
            signal_d  = ALU_AND;
            dataA_d   = '0;
            dataB_d   = '0;
            shamt_d   = '0;
            rd_d      = '0;
            ctrl_d    = '0;
            store_d   = '0;
            // an unsupported instruction still leaves a bubble, but flags it
            illegal_d = ~flush & id_valid & ~hazard & dec_illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signal_q  <= ALU_AND;
            dataA_q   <= '0;
            dataB_q   <= '0;
            shamt_q   <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
            store_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            signal_q  <= signal_d;
            dataA_q   <= dataA_d;
            dataB_q   <= dataB_d;
            shamt_q   <= shamt_d;
            rd_q      <= rd_d;
            ctrl_q    <= ctrl_d;
            store_q   <= store_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_signal     = signal_q;
    assign ex_dataA      = dataA_q;
    assign ex_dataB      = dataB_q;
    assign ex_shamt      = shamt_q;
    assign ex_rd         = rd_q;
    assign ex_regwrite   = ctrl_q.regwrite;
    assign ex_memread    = ctrl_q.memread;
    assign ex_memwrite   = ctrl_q.memwrite;
    assign ex_branch     = ctrl_q.branch;
    assign ex_valid      = ctrl_q.valid;
    assign ex_store_data = store_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases followed by random
// traffic, all compared against an instruction-level reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [5:0]  id_opcode = '0, id_funct = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0, id_shamt = '0;
  logic [15:0] id_imm = '0;
  logic [31:0] id_rs_data = '0, id_rt_data = '0, ex_alu_result = '0, mem_result = '0;
  logic        mem_regwrite = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic        ext_stall = 1'b0, flush = 1'b0;
  logic [2:0]  ex_signal;
  logic [31:0] ex_dataA, ex_dataB, ex_store_data;
  logic [4:0]  ex_shamt, ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_valid;
  logic        hazard_stall, illegal;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_imm(id_imm),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .ex_alu_result(ex_alu_result),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .ext_stall(ext_stall), .flush(flush), .ex_signal(ex_signal), .ex_dataA(ex_dataA),
    .ex_dataB(ex_dataB), .ex_shamt(ex_shamt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_valid(ex_valid), .ex_store_data(ex_store_data), .hazard_stall(hazard_stall),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  sig;
    logic [31:0] a, b;
    logic [4:0]  sh, rd;
    logic        rw, mr, mw, br, v;
    logic [31:0] st;
    logic        ill;
  } exp_t;

  typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SRL,
                M_ADDI, M_LW, M_SW, M_BEQ, M_NOP, M_BAD} mn_t;

  exp_t m = '0;        // what the EX register should hold now
  int   n_chk = 0, n_err = 0;
  logic last_hz;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t dut_now();
    exp_t r;
    r = {ex_signal, ex_dataA, ex_dataB, ex_shamt, ex_rd, ex_regwrite, ex_memread,
         ex_memwrite, ex_branch, ex_valid, ex_store_data, illegal};
    return r;
  endfunction

  // ---------------- reference model ----------------
  function automatic mn_t classify();
    if (id_opcode == 6'h00) begin
      if (id_rs == 0 && id_rt == 0 && id_imm == 0) return M_NOP;
      case (id_funct)
        6'h20: return M_ADD;
        6'h22: return M_SUB;
        6'h24: return M_AND;
        6'h25: return M_OR;
        6'h2A: return M_SLT;
        6'h02: return M_SRL;
        default: return M_BAD;
      endcase
    end
    case (id_opcode)
      6'h08: return M_ADDI;
      6'h23: return M_LW;
      6'h2B: return M_SW;
      6'h04: return M_BEQ;
      default: return M_BAD;
    endcase
  endfunction

  function automatic bit reads_rs(input mn_t k);
    return !(k inside {M_SRL, M_NOP, M_BAD});
  endfunction

  function automatic bit reads_rt(input mn_t k);
    return k inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SRL, M_SW, M_BEQ};
  endfunction

  // value an operand should have when EX reads it
  function automatic logic [31:0] opnd(input logic [4:0] src, input logic [31:0] rf);
`ifdef ID_EX_FWD_EN
    if (src != 0 && m.v && m.rw && !m.mr && m.rd == src) return ex_alu_result;
    if (src != 0 && mem_regwrite && mem_rd == src) return mem_result;
`endif
    return rf;
  endfunction

  // source register that must not be read yet
  function automatic bit blocked(input logic [4:0] src);
    if (src == 0) return 1'b0;
`ifdef ID_EX_FWD_EN
    return m.v && m.mr && m.rd == src;
`else
    return (m.v && m.rw && m.rd == src) || (mem_regwrite && mem_rd == src);
`endif
  endfunction

  function automatic bit model_haz();
    mn_t k;
    k = classify();
    return id_valid && ((reads_rs(k) && blocked(id_rs)) || (reads_rt(k) && blocked(id_rt)));
  endfunction

  function automatic exp_t model_next(input bit hz);
    exp_t n;
    mn_t  k;
    n = '0;
    k = classify();
    if (flush) return n;
    if (ext_stall) return m;
    if (hz || !id_valid || k == M_NOP) return n;
    if (k == M_BAD) begin n.ill = 1'b1; return n; end
    n.v = 1'b1;
    case (k)
      M_AND:         n.sig = 3'b000;
      M_OR:          n.sig = 3'b001;
      M_SRL:         n.sig = 3'b011;
      M_SUB, M_BEQ:  n.sig = 3'b110;
      M_SLT:         n.sig = 3'b111;
      default:       n.sig = 3'b010;
    endcase
    n.a  = opnd(id_rs, id_rs_data);
    n.st = opnd(id_rt, id_rt_data);
    n.b  = (k inside {M_ADDI, M_LW, M_SW}) ? {{16{id_imm[15]}}, id_imm} : n.st;
    n.sh = (k == M_SRL) ? id_shamt : 5'd0;
    n.rd = (k inside {M_ADDI, M_LW}) ? id_rt : ((k inside {M_SW, M_BEQ}) ? 5'd0 : id_rd);
    n.rw = (n.rd != 0);
    n.mr = (k == M_LW);
    n.mw = (k == M_SW);
    n.br = (k == M_BEQ);
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_r(input logic [5:0] fn, input logic [4:0] rs, rt, rd, sh);
    id_opcode = 6'h00; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd; id_shamt = sh;
    id_imm = {rd, sh, fn};
  endtask

  task automatic set_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    id_opcode = op; id_rs = rs; id_rt = rt; id_imm = imm;
    id_rd = imm[15:11]; id_shamt = imm[10:6]; id_funct = imm[5:0];
  endtask

  // called at posedge+1: check hazard before the edge, outputs after it
  task automatic step(input string tag);
    exp_t nx;
    bit   hz;
    #4;
    hz = model_haz();
    nx = model_next(hz);
    last_hz = hazard_stall;
    chk({tag, ":hazard"}, {127'd0, hazard_stall}, {127'd0, hz && !flush});
    @(posedge clk);
    #1;
    m = nx;
    chk({tag, ":ex"}, dut_now(), m);
  endtask

  initial begin
    logic [31:0] shifted;
    @(posedge clk); #1;
    chk("reset", dut_now(), '0);
    chk("reset_hz", {127'd0, hazard_stall}, '0);
    rst = 1'b0;

    // add $3,$1,$2
    id_valid = 1'b1; set_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
    id_rs_data = 32'd5; id_rt_data = 32'd7;
    step("add");
    chk("add_sig", ex_signal, 3'b010);
    chk("add_ab", {ex_dataA, ex_dataB}, {32'd5, 32'd7});
    chk("add_rd_rw", {ex_rd, ex_regwrite}, {5'd3, 1'b1});

    // srl $4,$0,$5,4
    set_r(6'h02, 5'd0, 5'd5, 5'd4, 5'd4);
    id_rs_data = 32'd0; id_rt_data = 32'hF0;
    step("srl");
    chk("srl_fields", {ex_signal, ex_dataB, ex_shamt}, {3'b011, 32'hF0, 5'd4});
    shifted = ex_dataB >> ex_shamt;
    chk("srl_result", shifted, 32'h0F);

    // EX holds add->$1, then sub $5,$1,$1
    set_r(6'h20, 5'd2, 5'd3, 5'd1, 5'd0);
    step("prod1");
    ex_alu_result = 32'h1234;
    set_r(6'h22, 5'd1, 5'd1, 5'd5, 5'd0);
    id_rs_data = 32'd0; id_rt_data = 32'd0;
    step("fwd_ex");
`ifdef ID_EX_FWD_EN
    chk("fwd_ex_ab", {ex_dataA, ex_dataB}, {32'h1234, 32'h1234});
`else
    chk("raw_ex_stall", {last_hz, ex_valid}, {1'b1, 1'b0});
`endif

    // MEM rd=$1 only
    mem_regwrite = 1'b1; mem_rd = 5'd1; mem_result = 32'd9;
    step("fwd_mem");
`ifdef ID_EX_FWD_EN
    chk("fwd_mem_ab", {ex_dataA, ex_dataB}, {32'd9, 32'd9});
`else
    chk("raw_mem_stall", {last_hz, ex_valid}, {1'b1, 1'b0});
`endif
    mem_regwrite = 1'b0;

    // lw $2,4($0) then add $6,$2,$2
    set_i(6'h23, 5'd0, 5'd2, 16'h0004);
    step("lw");
    chk("lw_ctrl", {ex_memread, ex_regwrite, ex_rd, ex_dataB}, {1'b1, 1'b1, 5'd2, 32'd4});
    set_r(6'h20, 5'd2, 5'd2, 5'd6, 5'd0);
    step("loaduse");
    chk("loaduse_bubble", {last_hz, ex_valid, ex_regwrite}, {1'b1, 1'b0, 1'b0});
    mem_regwrite = 1'b1; mem_rd = 5'd2; mem_result = 32'h77;
    step("after_lu");
`ifdef ID_EX_FWD_EN
    chk("after_lu_fwd", {last_hz, ex_dataA}, {1'b0, 32'h77});
`else
    chk("after_lu_stall", {last_hz, ex_valid}, {1'b1, 1'b0});
`endif
    mem_regwrite = 1'b0;

    // flush + ext_stall with beq in ID
    set_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
    step("pre_flush");
    set_i(6'h04, 5'd1, 5'd2, 16'h0010);
    flush = 1'b1; ext_stall = 1'b1;
    step("flush_stall");
    chk("flush_bubble", {ex_valid, ex_branch, ex_regwrite}, 3'b000);
    flush = 1'b0; ext_stall = 1'b0;
    step("beq");
    chk("beq_ctrl", {ex_signal, ex_branch, ex_valid, ex_regwrite}, {3'b110, 1'b1, 1'b1, 1'b0});
    ext_stall = 1'b1;
    set_i(6'h08, 5'd3, 5'd4, 16'hFFFF);
    step("hold");
    chk("hold_beq", {ex_signal, ex_branch, ex_valid}, {3'b110, 1'b1, 1'b1});
    ext_stall = 1'b0;

    // unsupported opcode
    set_i(6'h3F, 5'd0, 5'd0, 16'h0000);
    step("illegal");
    chk("illegal_flag", {illegal, ex_valid}, {1'b1, 1'b0});
    id_valid = 1'b0;
    step("illegal_clr");
    chk("illegal_gone", {27'd0, illegal}, '0);

    // async reset between edges
    id_valid = 1'b1; set_r(6'h25, 5'd1, 5'd2, 5'd7, 5'd0);
    step("pre_rst");
    #2 rst = 1'b1;
    #1 chk("async_rst", dut_now(), '0);
    @(posedge clk); #1;
    rst = 1'b0; m = '0;

    // random traffic over a small register window so hazards are frequent
    for (int i = 0; i < 600; i++) begin
      int unsigned k;
      logic [4:0] rs, rt, rd;
      logic [5:0] fns [6];
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h02};
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      k  = $urandom_range(0, 19);
      if (k < 8)       set_r(fns[$urandom_range(0, 5)], rs, rt, rd, 5'($urandom_range(0, 31)));
      else if (k < 10) set_i(6'h08, rs, rt, 16'($urandom));
      else if (k < 13) set_i(6'h23, rs, rt, 16'($urandom));
      else if (k < 15) set_i(6'h2B, rs, rt, 16'($urandom));
      else if (k < 17) set_i(6'h04, rs, rt, 16'($urandom));
      else if (k == 17) set_i(6'h00, 5'd0, 5'd0, 16'h0000);
      else if (k == 18) set_r(6'h00, rs, rt, 5'd1, 5'd3);
      else             set_i(6'($urandom_range(48, 63)), rs, rt, 16'($urandom));
      id_valid      = ($urandom_range(0, 9) != 0);
      id_rs_data    = $urandom;
      id_rt_data    = $urandom;
      ex_alu_result = $urandom;
      mem_result    = $urandom;
      mem_regwrite  = 1'($urandom_range(0, 1));
      mem_rd        = 5'($urandom_range(0, 3));
      ext_stall     = ($urandom_range(0, 9) == 0);
      flush         = ($urandom_range(0, 19) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_err);
    $finish;
  end

endmodule
